// File: rtl/datapath_seq_pkg.sv
// datapath_seq_pkg: shared widths, sequencer states, opcode constants and halt decode
// Imported by the interface, the program buffer and the sequencer top.
package datapath_seq_pkg;
   localparam int ISIZE = 16;
   localparam int DSIZE = 16;
   localparam int DEPTH = 16;
   localparam int AW = 4;
   localparam int ISSUE_CYCLES = 2;
   localparam int CW = $clog2(ISSUE_CYCLES + 1);
   localparam logic [3:0] HALT_OP = 4'hF;
   localparam logic [ISIZE-1:0] NOP_INSTR = 16'h0000;
   typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;
   function automatic logic is_halt(input logic [ISIZE-1:0] w);
      return w[ISIZE-1 -: 4] == HALT_OP;
   endfunction
endpackage

// File: rtl/datapath_seq_if.sv
// datapath_seq_if: host and datapath signals of the program sequencer
// host side: prog_we/prog_addr/prog_data, init_valid/init_data/init_ready,
//            start, abort, busy, done, err, pc, result, result_valid
// datapath side: Instruction, InitSel, DataInit out; ALUOut in
// slave = sequencer, master = host/datapath environment
interface datapath_seq_if;
   import datapath_seq_pkg::*;
   logic             prog_we;
   logic [AW-1:0]    prog_addr;
   logic [ISIZE-1:0] prog_data;
   logic             init_valid;
   logic [DSIZE-1:0] init_data;
   logic             init_ready;
   logic             start;
   logic             abort;
   logic             busy;
   logic             done;
   logic             err;
   logic [AW-1:0]    pc;
   logic [ISIZE-1:0] Instruction;
   logic             InitSel;
   logic [DSIZE-1:0] DataInit;
   logic [DSIZE-1:0] ALUOut;
   logic [DSIZE-1:0] result;
   logic             result_valid;
   modport slave (
      input  prog_we, prog_addr, prog_data, init_valid, init_data, start, abort, ALUOut,
      output init_ready, busy, done, err, pc, Instruction, InitSel, DataInit, result, result_valid
   );
   modport master (
      output prog_we, prog_addr, prog_data, init_valid, init_data, start, abort, ALUOut,
      input  init_ready, busy, done, err, pc, Instruction, InitSel, DataInit, result, result_valid
   );
endinterface

// File: rtl/datapath_seq_buf.sv
// datapath_seq_buf: DEPTH x ISIZE program store, one sync write port, one async read port, no reset
// clk; we_i/waddr_i/wdata_i write port; raddr_i -> rdata_o combinational read
module datapath_seq_buf
   import datapath_seq_pkg::*;
(
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [ISIZE-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [ISIZE-1:0] rdata_o
);
   logic [ISIZE-1:0] mem_q [DEPTH];
   always_ff @(posedge clk)
      if (we_i) mem_q[waddr_i] <= wdata_i;
   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/datapath_seq.sv
// datapath_seq: program sequencer that preloads and then steps the 16-bit datapath
// clk: rising-edge clock; reset: asynchronous active-low
// bus (slave): host program/init/run control and status, datapath drive and ALUOut capture
module datapath_seq
   import datapath_seq_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   datapath_seq_if.slave  bus
);
   state_t           state_q, state_d;
   logic [CW-1:0]    hold_q, hold_d;
   logic [AW-1:0]    pc_q, pc_d;
   logic [ISIZE-1:0] instr_q, instr_d;
   logic             isel_q, isel_d;
   logic [DSIZE-1:0] dinit_q, dinit_d;
   logic [DSIZE-1:0] res_q, res_d;
   logic             rv_q, rv_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             busy_q;
   logic             buf_we;
   logic [AW-1:0]    raddr;
   logic [ISIZE-1:0] rdata;
   logic [ISIZE-1:0] nxt_w;
   logic             hold_end;
   logic             last;

   assign buf_we   = bus.prog_we && state_q == IDLE;
   // in IDLE the next word is entry 0 (for start), in RUN it is the successor of pc
   assign raddr    = state_q == RUN ? pc_q + 1'b1 : '0;
   // a write landing on the word being fetched must be seen by a start in the same cycle
   assign nxt_w    = (buf_we && bus.prog_addr == raddr) ? bus.prog_data : rdata;
   assign hold_end = hold_q == CW'(ISSUE_CYCLES - 1);
   assign last     = pc_q == AW'(DEPTH - 1);

   datapath_seq_buf u_buf (
      .clk    (clk),
      .we_i   (buf_we),
      .waddr_i(bus.prog_addr),
      .wdata_i(bus.prog_data),
      .raddr_i(raddr),
      .rdata_o(rdata)
   );

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      isel_d  = isel_q;
      dinit_d = dinit_q;
      res_d   = res_q;
      rv_d    = 1'b0;
      done_d  = 1'b0;
      err_d   = err_q;
      if (bus.abort) begin
         state_d = IDLE;
         instr_d = NOP_INSTR;
         isel_d  = 1'b0;
         dinit_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.init_valid) begin
                  state_d = INIT;
                  isel_d  = 1'b1;
                  dinit_d = bus.init_data;
                  hold_d  = '0;
               end else if (bus.start) begin
                  err_d  = 1'b0;
                  pc_d   = '0;
                  hold_d = '0;
                  if (is_halt(nxt_w)) done_d = 1'b1;
                  else begin
                     state_d = RUN;
                     instr_d = nxt_w;
                  end
               end
            end
            INIT: begin
               if (hold_end) begin
                  state_d = IDLE;
                  isel_d  = 1'b0;
                  dinit_d = '0;
               end else hold_d = hold_q + 1'b1;
            end
            RUN: begin
               if (!hold_end) hold_d = hold_q + 1'b1;
               else begin
                  res_d  = bus.ALUOut;
                  rv_d   = 1'b1;
                  hold_d = '0;
                  // running off the end of the buffer without a HALT is an overrun
                  if (last || is_halt(nxt_w)) begin
                     err_d   = err_q | last;
                     done_d  = 1'b1;
                     instr_d = NOP_INSTR;
                     state_d = IDLE;
                  end else begin
                     pc_d    = pc_q + 1'b1;
                     instr_d = nxt_w;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         hold_q  <= '0;
         pc_q    <= '0;
         instr_q <= NOP_INSTR;
         isel_q  <= 1'b0;
         dinit_q <= '0;
         res_q   <= '0;
         rv_q    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         isel_q  <= isel_d;
         dinit_q <= dinit_d;
         res_q   <= res_d;
         rv_q    <= rv_d;
         done_q  <= done_d;
         err_q   <= err_d;
         busy_q  <= state_d != IDLE;
      end
   end

   assign bus.init_ready   = state_q == IDLE;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.err          = err_q;
   assign bus.pc           = pc_q;
   assign bus.Instruction  = instr_q;
   assign bus.InitSel      = isel_q;
   assign bus.DataInit     = dinit_q;
   assign bus.result       = res_q;
   assign bus.result_valid = rv_q;
endmodule

// File: tb/tb_datapath_seq.sv
// tb_datapath_seq: self-checking bench for datapath_seq with a result scoreboard
module tb_datapath_seq;
   import datapath_seq_pkg::*;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   datapath_seq_if bus ();
   datapath_seq dut (.clk(clk), .reset(reset), .bus(bus));

   // datapath model: ALUOut is a fixed function of the instruction being held
   assign bus.ALUOut = bus.Instruction ^ 16'h5A5A;

   int n_cmp = 0;
   int n_bad = 0;
   int done_cnt = 0;
   int rv_cnt = 0;
   logic [DSIZE-1:0] sb_q [$];
   logic [ISIZE-1:0] model [DEPTH];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.done) done_cnt++;
      if (bus.result_valid) begin
         rv_cnt++;
         if (sb_q.size() == 0) check("sb_underflow", 32'(sb_q.size()), 1);
         else check("result", bus.result, sb_q.pop_front());
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [AW-1:0] a, input logic [ISIZE-1:0] d);
      bus.prog_we = 1'b1;
      bus.prog_addr = a;
      bus.prog_data = d;
      model[a] = d;
      tick();
      bus.prog_we = 1'b0;
   endtask

   task automatic push_run;
      for (int p = 0; p < DEPTH; p++) begin
         if (model[p][15:12] == 4'hF) break;
         sb_q.push_back(model[p] ^ 16'h5A5A);
      end
   endtask

   task automatic start_run;
      push_run();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         tick();
         seen = bus.done;
      end
      check("done_seen", seen, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0;
      int d0;
      bus.prog_we = 0; bus.prog_addr = '0; bus.prog_data = '0;
      bus.init_valid = 0; bus.init_data = '0; bus.start = 0; bus.abort = 0;
      #12;
      check("rst_instr", bus.Instruction, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_ready", bus.init_ready, 1);
      check("rst_result", bus.result, 0);
      check("rst_pc", bus.pc, 0);
      check("rst_err", bus.err, 0);
      check("rst_done", bus.done, 0);
      check("rst_isel", bus.InitSel, 0);
      reset = 1'b1;
      tick();
      // basic program
      load(0, 16'h1234); load(1, 16'h5678); load(2, 16'hF000);
      r0 = rv_cnt;
      start_run();
      check("t1_i0a", bus.Instruction, 16'h1234);
      check("t1_busy", bus.busy, 1);
      check("t1_pc0", bus.pc, 0);
      tick(); check("t1_i0b", bus.Instruction, 16'h1234);
      tick(); check("t1_i1a", bus.Instruction, 16'h5678);
      check("t1_pc1", bus.pc, 1);
      tick(); check("t1_i1b", bus.Instruction, 16'h5678);
      tick();
      check("t1_done", bus.done, 1);
      check("t1_nop", bus.Instruction, 0);
      check("t1_idle", bus.busy, 0);
      check("t1_pcend", bus.pc, 1);
      check("t1_err", bus.err, 0);
      tick();
      check("t1_rvcnt", rv_cnt - r0, 2);
      check("t1_sb", 32'(sb_q.size()), 0);
      // init path
      bus.init_valid = 1; bus.init_data = 16'hABCD;
      tick();
      bus.init_valid = 0;
      check("t2_isel", bus.InitSel, 1);
      check("t2_dinit", bus.DataInit, 16'hABCD);
      check("t2_ready", bus.init_ready, 0);
      tick(); check("t2_isel2", bus.InitSel, 1);
      tick();
      check("t2_isel_off", bus.InitSel, 0);
      check("t2_dinit_off", bus.DataInit, 0);
      check("t2_ready_on", bus.init_ready, 1);
      // halt at entry 0
      load(0, 16'hF000);
      r0 = rv_cnt;
      start_run();
      check("t3_done", bus.done, 1);
      check("t3_nop", bus.Instruction, 0);
      tick();
      check("t3_done_pulse", bus.done, 0);
      check("t3_norv", rv_cnt - r0, 0);
      // overrun through all entries
      for (int a = 0; a < DEPTH; a++) load(AW'(a), 16'h1001);
      r0 = rv_cnt;
      start_run();
      wait_done(100);
      check("t4_err", bus.err, 1);
      check("t4_nop", bus.Instruction, 0);
      check("t4_pc", bus.pc, DEPTH - 1);
      tick();
      check("t4_rvcnt", rv_cnt - r0, 16);
      start_run();
      check("t4_err_clr", bus.err, 0);
      wait_done(100);
      check("t4_err2", bus.err, 1);
      tick();
      check("t4_sb", 32'(sb_q.size()), 0);
      // abort during the second instruction
      load(0, 16'h1111); load(1, 16'h2222); load(2, 16'hF000);
      sb_q.push_back(16'h1111 ^ 16'h5A5A);
      d0 = done_cnt;
      bus.start = 1; tick(); bus.start = 0;
      tick();
      tick(); check("t5_i1", bus.Instruction, 16'h2222);
      bus.abort = 1;
      tick();
      bus.abort = 0;
      check("t5_nop", bus.Instruction, 0);
      check("t5_busy", bus.busy, 0);
      check("t5_nodone", bus.done, 0);
      tick(); tick();
      check("t5_donecnt", done_cnt - d0, 0);
      check("t5_sb", 32'(sb_q.size()), 0);
      check("t5_ready", bus.init_ready, 1);
      // asynchronous reset mid-run
      bus.start = 1; tick(); bus.start = 0;
      tick();
      #2 reset = 1'b0;
      #1;
      check("t5r_instr", bus.Instruction, 0);
      check("t5r_result", bus.result, 0);
      check("t5r_busy", bus.busy, 0);
      check("t5r_ready", bus.init_ready, 1);
      reset = 1'b1;
      tick();
      // start and init together: init wins
      d0 = done_cnt;
      bus.start = 1; bus.init_valid = 1; bus.init_data = 16'h5555;
      tick();
      bus.start = 0; bus.init_valid = 0;
      check("t6_isel", bus.InitSel, 1);
      check("t6_instr", bus.Instruction, 0);
      tick(); tick();
      check("t6_ready", bus.init_ready, 1);
      tick();
      check("t6_norun", bus.Instruction, 0);
      check("t6_nodone", done_cnt - d0, 0);
      // write during RUN is dropped
      start_run();
      tick();
      bus.prog_we = 1; bus.prog_addr = 1; bus.prog_data = 16'hF000;
      tick();
      bus.prog_we = 0;
      wait_done(20);
      start_run();
      tick(); tick();
      check("t6_readback", bus.Instruction, 16'h2222);
      wait_done(20);
      tick();
      check("t6_sb", 32'(sb_q.size()), 0);
      // write and start in the same cycle
      bus.prog_we = 1; bus.prog_addr = 0; bus.prog_data = 16'h3333;
      model[0] = 16'h3333;
      push_run();
      bus.start = 1;
      tick();
      bus.prog_we = 0; bus.start = 0;
      check("t6_fwd", bus.Instruction, 16'h3333);
      wait_done(20);
      tick();
      check("t6_sb2", 32'(sb_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
